// File: rtl/apb_multi_bridge_pkg.sv
// Shared FSM state encodings and response codes for the APB multi-completer bridge.
package apb_multi_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t SETUP  = 2'd1;
    localparam state_t ACCESS = 2'd2;
    localparam state_t RESP   = 2'd3;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_SLVERR  = 2'b01;
    localparam logic [1:0] RSP_DECERR  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_slv_decoder.sv
// Combinational address decoder: completer index, one-hot select and decode error.
module apb_slv_decoder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NSLV   = 4,
    parameter int unsigned SLV_AW = 8
) (
    input  logic [ADDR_W-1:0]        addr,
    output logic [$clog2(NSLV)-1:0]  idx,
    output logic [NSLV-1:0]          sel,
    output logic                     decerr
);

    localparam int unsigned IDX_W  = $clog2(NSLV);
    localparam int unsigned HI_LSB = SLV_AW + IDX_W;

    always_comb begin
        idx    = addr[SLV_AW +: IDX_W];
        // Any address bit above the decoded region makes the access unmapped.
        decerr = (32'(idx) >= NSLV) || (|(addr >> HI_LSB));
        sel    = '0;
        if (!decerr) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_multi_bridge.sv
// Single-outstanding request/response port to APB requester with address decode,
// wait-state handling, per-completer response mux, decode-error and timeout reporting.
module apb_multi_bridge
    import apb_multi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SLV_AW  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [1:0]             rsp_err,
    output logic [NSLV-1:0]        PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [DATA_W-1:0]      PWDATA,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);

    localparam int unsigned IDX_W = $clog2(NSLV);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   dec_idx;
    logic [NSLV-1:0]    dec_sel;
    logic               dec_err;

    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timeout_hit;

    apb_slv_decoder #(
        .ADDR_W (ADDR_W),
        .NSLV   (NSLV),
        .SLV_AW (SLV_AW)
    ) u_decoder (
        .addr   (req_addr),
        .idx    (dec_idx),
        .sel    (dec_sel),
        .decerr (dec_err)
    );

    // Only the selected completer is observed; all others are ignored.
    always_comb begin
        sel_ready   = PREADY[idx_q];
        sel_err     = PSLVERR[idx_q];
        sel_rdata   = PRDATA[idx_q*DATA_W +: DATA_W];
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= RSP_OK;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (dec_err) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= RSP_DECERR;
                            rsp_rdata <= '0;
                        end else begin
                            state_q <= SETUP;
                            idx_q   <= dec_idx;
                            PSEL    <= dec_sel;
                            PWRITE  <= req_write;
                            PADDR   <= ADDR_W'(req_addr[SLV_AW-1:0]);
                            PWDATA  <= req_write ? req_wdata : '0;
                        end
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    PENABLE <= 1'b1;
                    cnt_q   <= '0;
                end
                ACCESS: begin
                    // Ready takes priority over a timeout in the same cycle.
                    if (sel_ready || timeout_hit) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        PWRITE    <= 1'b0;
                        PADDR     <= '0;
                        PWDATA    <= '0;
                        if (sel_ready) begin
                            rsp_err   <= sel_err ? RSP_SLVERR : RSP_OK;
                            rsp_rdata <= PWRITE ? '0 : sel_rdata;
                        end else begin
                            rsp_err   <= RSP_TIMEOUT;
                            rsp_rdata <= '0;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= RSP_OK;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_multi_bridge.sv
// Directed bench for apb_multi_bridge: expected responses queued at issue time and
// compared when rsp_valid pulses; APB-side timing checked inline.
module tb_apb_multi_bridge;
    import apb_multi_bridge_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NSLV    = 4;
    localparam int unsigned SLV_AW  = 8;
    localparam int unsigned TIMEOUT = 16;

    logic                   PCLK = 1'b0;
    logic                   PRESET = 1'b1;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic [1:0]             rsp_err;
    logic [NSLV-1:0]        PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic [NSLV*DATA_W-1:0] PRDATA;
    logic [NSLV-1:0]        PREADY;
    logic [NSLV-1:0]        PSLVERR;

    int checks  = 0;
    int errors  = 0;
    int pushed  = 0;
    int dropped = 0;
    int seen    = 0;
    int en_cnt;
    logic [DATA_W+1:0] exp_q[$];
    logic [DATA_W+1:0] mon_e;

    apb_multi_bridge #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSLV    (NSLV),
        .SLV_AW  (SLV_AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    // Drive one request at the current falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic [1:0] ee);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        exp_q.push_back({er, ee});
        pushed++;
        @(negedge PCLK);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Response scoreboard.
    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid === 1'b1) begin
            seen++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[DATA_W+1:2]));
                chk("rsp_err", 64'(rsp_err), 64'(mon_e[1:0]));
            end
        end
    end

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = '0;
        PSLVERR   = '0;
        PRDATA    = {NSLV{32'hFFFF_FFFF}};

        // Reset values
        cyc(1);
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        PRESET = 1'b0;
        cyc(1);
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // Zero-wait write to completer 2
        issue(1'b1, 32'h210, 32'hDEAD_BEEF, 32'h0, RSP_OK);
        chk("wr_setup_psel", 64'(PSEL), 64'b0100);
        chk("wr_setup_penable", 64'(PENABLE), 64'd0);
        chk("wr_setup_paddr", 64'(PADDR), 64'h10);
        chk("wr_setup_pwrite", 64'(PWRITE), 64'd1);
        chk("wr_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
        chk("wr_setup_ready", 64'(req_ready), 64'd0);
        PREADY = 4'b0100;
        cyc(1);
        chk("wr_access_penable", 64'(PENABLE), 64'd1);
        chk("wr_access_psel", 64'(PSEL), 64'b0100);
        chk("wr_access_paddr", 64'(PADDR), 64'h10);
        cyc(1);
        chk("wr_resp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_resp_psel", 64'(PSEL), 64'd0);
        chk("wr_resp_penable", 64'(PENABLE), 64'd0);
        chk("wr_resp_paddr", 64'(PADDR), 64'd0);
        chk("wr_resp_pwdata", 64'(PWDATA), 64'd0);
        PREADY = '0;
        cyc(1);
        chk("wr_idle_ready", 64'(req_ready), 64'd1);
        chk("wr_idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // Read from completer 1 with three wait states; other completers ready but ignored
        PRDATA = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF};
        PREADY = 4'b1101;
        issue(1'b0, 32'h105, 32'h55AA_55AA, 32'h1234_5678, RSP_OK);
        chk("rd_setup_psel", 64'(PSEL), 64'b0010);
        chk("rd_setup_paddr", 64'(PADDR), 64'h05);
        chk("rd_setup_pwrite", 64'(PWRITE), 64'd0);
        chk("rd_setup_pwdata", 64'(PWDATA), 64'd0);
        cyc(3);
        chk("rd_wait_penable", 64'(PENABLE), 64'd1);
        chk("rd_wait_rsp_valid", 64'(rsp_valid), 64'd0);
        cyc(1);
        chk("rd_ready_cycle_penable", 64'(PENABLE), 64'd1);
        PREADY = 4'b1111;
        cyc(1);
        chk("rd_resp_valid_c6", 64'(rsp_valid), 64'd1);
        PREADY = '0;
        cyc(1);

        // Decode error: address above the mapped window
        PREADY = 4'b1111;
        issue(1'b1, 32'h400, 32'h1, 32'h0, RSP_DECERR);
        chk("dec_rsp_valid_c1", 64'(rsp_valid), 64'd1);
        chk("dec_psel_c1", 64'(PSEL), 64'd0);
        cyc(1);
        chk("dec_psel_c2", 64'(PSEL), 64'd0);
        chk("dec_ready_c2", 64'(req_ready), 64'd1);
        PREADY = '0;

        // Timeout on completer 3 while the others are ready
        PREADY = 4'b0111;
        issue(1'b0, 32'h3F0, 32'h0, 32'h0, RSP_TIMEOUT);
        chk("to_setup_psel", 64'(PSEL), 64'b1000);
        chk("to_setup_paddr", 64'(PADDR), 64'hF0);
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (rsp_valid === 1'b1) break;
            if (PENABLE === 1'b1) en_cnt++;
        end
        chk("to_access_len", 64'(en_cnt), 64'(TIMEOUT));
        chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
        PREADY = '0;
        cyc(1);

        // Follow-up write completes normally
        issue(1'b1, 32'h000, 32'hCAFE_F00D, 32'h0, RSP_OK);
        chk("fu_psel", 64'(PSEL), 64'b0001);
        chk("fu_paddr", 64'(PADDR), 64'h0);
        PREADY = 4'b0001;
        cyc(1);
        chk("fu_penable", 64'(PENABLE), 64'd1);
        cyc(1);
        chk("fu_rsp_valid", 64'(rsp_valid), 64'd1);
        PREADY = '0;
        cyc(1);

        // Completer error on 0, with completer 2 signalling ready/error meanwhile
        issue(1'b1, 32'h0FF, 32'h0BAD_F00D, 32'h0, RSP_SLVERR);
        chk("se_psel", 64'(PSEL), 64'b0001);
        chk("se_paddr", 64'(PADDR), 64'hFF);
        chk("se_pwdata", 64'(PWDATA), 64'h0BAD_F00D);
        PREADY  = 4'b0100;
        PSLVERR = 4'b0100;
        cyc(2);
        chk("se_iso_penable", 64'(PENABLE), 64'd1);
        chk("se_iso_psel", 64'(PSEL), 64'b0001);
        chk("se_iso_rsp_valid", 64'(rsp_valid), 64'd0);
        PREADY  = 4'b0101;
        PSLVERR = 4'b0001;
        cyc(1);
        chk("se_rsp_valid", 64'(rsp_valid), 64'd1);
        PREADY  = '0;
        PSLVERR = '0;
        cyc(1);

        // Asynchronous reset in the middle of ACCESS
        issue(1'b1, 32'h2AA, 32'h1357_2468, 32'h0, RSP_OK);
        cyc(1);
        chk("ar_penable_before", 64'(PENABLE), 64'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("ar_psel", 64'(PSEL), 64'd0);
        chk("ar_penable", 64'(PENABLE), 64'd0);
        chk("ar_pwrite", 64'(PWRITE), 64'd0);
        chk("ar_paddr", 64'(PADDR), 64'd0);
        chk("ar_pwdata", 64'(PWDATA), 64'd0);
        chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("ar_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("ar_rsp_err", 64'(rsp_err), 64'd0);
        exp_q.delete();
        dropped++;
        cyc(1);
        PRESET = 1'b0;
        cyc(1);
        chk("ar_ready_after", 64'(req_ready), 64'd1);
        cyc(3);
        chk("ar_no_stray_rsp", 64'(rsp_valid), 64'd0);

        chk("rsp_count", 64'(seen), 64'(pushed - dropped));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
